// File: rtl/iforest_pkg.sv
// iforest_pkg: shared types and width helpers for the isolation-tree path scorer.
//   state_e       : walk controller states (IDLE, WALK, DONE)
//   node_entry_t  : {leaf, feat_idx, thr} node layout for the default
//                   configuration (DATA_W=8, N_FEAT=2)
//   fi_width()    : feature-index width, max(1, clog2(N_FEAT))
//   pl_width()    : path-length width, clog2(DEPTH+1)
//   addr_width()  : node-address width, max(1, clog2(NODES))
package iforest_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int fi_width(input int n_feat);
    return (n_feat > 1) ? $clog2(n_feat) : 1;
  endfunction

  function automatic int pl_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int addr_width(input int nodes);
    return (nodes > 1) ? $clog2(nodes) : 1;
  endfunction

  localparam int DEF_DATA_W = 8;
  localparam int DEF_N_FEAT = 2;
  localparam int DEF_FI_W   = fi_width(DEF_N_FEAT);

  typedef struct packed {
    logic                  leaf;
    logic [DEF_FI_W-1:0]   feat_idx;
    logic [DEF_DATA_W-1:0] thr;
  } node_entry_t;

endpackage

// File: rtl/iforest_node_table.sv
// iforest_node_table: NODES-entry register file holding the isolation tree.
//   clk, reset : rising-edge clock, synchronous active-high clear of all entries
//   we, waddr, wdata : synchronous write port (caller qualifies we)
//   raddr, rdata     : combinational read port; out-of-range reads return zero
module iforest_node_table
  import iforest_pkg::*;
#(
  parameter int NODES = 15,
  parameter int AW    = 4,
  parameter int EW    = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [EW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [EW-1:0] rdata
);

  localparam logic [AW-1:0] NODES_A = AW'(NODES);

  logic [EW-1:0] mem_q [NODES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NODES; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // The walker's node register may hold a truncated child index after the
  // final level; such reads must not index past the array.
  assign rdata = (raddr < NODES_A) ? mem_q[raddr] : '0;

endmodule

// File: rtl/iforest_path_scorer.sv
// iforest_path_scorer: walks one sample through a runtime-loaded isolation
// tree, one node per clock, and reports path length plus anomaly flag.
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   sample_in/in_valid/in_ready : sample input handshake (ready only in IDLE)
//   score_thr             : anomaly threshold, captured with the sample
//   cfg_we/cfg_addr/cfg_data : node writes {leaf, feat_idx, thr}, IDLE only
//   cfg_err               : sticky flag for dropped node writes
//   out_valid/out_ready   : result handshake, result held until accepted
//   path_len, anomaly     : levels traversed, path_len <= captured threshold
//   anomaly_cnt           : saturating anomaly counter when the build macro
//                           ITREE_ANOMALY_COUNT_EN is defined, else tied to 0
module iforest_path_scorer
  import iforest_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int N_FEAT = 2,
  parameter  int DEPTH  = 4,
  localparam int FI_W   = fi_width(N_FEAT),
  localparam int PL_W   = pl_width(DEPTH),
  localparam int NODES  = (1 << DEPTH) - 1,
  localparam int AW     = addr_width(NODES),
  localparam int EW     = 1 + FI_W + DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_FEAT*DATA_W-1:0] sample_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PL_W-1:0]          score_thr,
  input  logic                     cfg_we,
  input  logic [AW-1:0]            cfg_addr,
  input  logic [EW-1:0]            cfg_data,
  output logic                     cfg_err,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PL_W-1:0]          path_len,
  output logic                     anomaly,
  output logic [15:0]              anomaly_cnt
);

  localparam logic [AW-1:0]   NODES_A = AW'(NODES);
  localparam logic [PL_W-1:0] DEPTH_L = PL_W'(DEPTH);

  state_e                   state_q, state_d;
  logic [AW-1:0]            node_q, node_d;
  logic [PL_W-1:0]          lvl_q, lvl_d;
  logic [N_FEAT*DATA_W-1:0] sample_q, sample_d;
  logic [PL_W-1:0]          sthr_q, sthr_d;
  logic                     out_valid_q, out_valid_d;
  logic [PL_W-1:0]          path_len_q, path_len_d;
  logic                     anomaly_q, anomaly_d;
  logic                     cfg_err_q, cfg_err_d;

  logic                     tbl_we;
  logic [EW-1:0]            entry;
  logic                     leaf;
  logic [FI_W-1:0]          fidx;
  logic [DATA_W-1:0]        nthr;
  logic [DATA_W-1:0]        feat_val;
  logic [AW:0]              node_dbl;
  logic [PL_W-1:0]          lvl_inc;
  logic                     fin;
  logic [PL_W-1:0]          fin_len;
  logic                     accept;
  logic                     out_hs;

  assign accept = in_valid && (state_q == IDLE);
  assign out_hs = out_valid_q && out_ready;
  assign tbl_we = cfg_we && (state_q == IDLE) && (cfg_addr < NODES_A);

  iforest_node_table #(
    .NODES (NODES),
    .AW    (AW),
    .EW    (EW)
  ) u_table (
    .clk   (clk),
    .reset (reset),
    .we    (tbl_we),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (node_q),
    .rdata (entry)
  );

  assign leaf = entry[EW-1];
  assign fidx = entry[DATA_W +: FI_W];
  assign nthr = entry[DATA_W-1:0];

  // Unmatched (out-of-range) feature indices fall back to feature 0.
  always_comb begin
    feat_val = sample_q[DATA_W-1:0];
    for (int f = 1; f < N_FEAT; f++) begin
      if (fidx == FI_W'(f)) feat_val = sample_q[f*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    node_d      = node_q;
    lvl_d       = lvl_q;
    sample_d    = sample_q;
    sthr_d      = sthr_q;
    out_valid_d = out_valid_q;
    path_len_d  = path_len_q;
    anomaly_d   = anomaly_q;
    cfg_err_d   = cfg_err_q | (cfg_we & ~tbl_we);
    node_dbl    = {node_q, 1'b0};
    lvl_inc     = lvl_q + PL_W'(1);
    fin         = 1'b0;
    fin_len     = lvl_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          sample_d = sample_in;
          sthr_d   = score_thr;
          node_d   = '0;
          lvl_d    = '0;
          state_d  = WALK;
        end
      end
      WALK: begin
        if (leaf) begin
          fin     = 1'b1;
          fin_len = lvl_q;
        end else begin
          lvl_d = lvl_inc;
          if (lvl_inc == DEPTH_L) begin
            fin     = 1'b1;
            fin_len = DEPTH_L;
          end else if (feat_val < nthr) begin
            node_d = node_dbl[AW-1:0] + AW'(1);
          end else begin
            node_d = node_dbl[AW-1:0] + AW'(2);
          end
        end
      end
      DONE: begin
        if (out_hs) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fin) begin
      state_d     = DONE;
      out_valid_d = 1'b1;
      path_len_d  = fin_len;
      anomaly_d   = (fin_len <= sthr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      node_q      <= '0;
      lvl_q       <= '0;
      out_valid_q <= 1'b0;
      path_len_q  <= '0;
      anomaly_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      node_q      <= node_d;
      lvl_q       <= lvl_d;
      out_valid_q <= out_valid_d;
      path_len_q  <= path_len_d;
      anomaly_q   <= anomaly_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // Captured sample and threshold are pure data: loaded on acceptance only.
  always_ff @(posedge clk) begin
    sample_q <= sample_d;
    sthr_q   <= sthr_d;
  end

`ifdef ITREE_ANOMALY_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    cnt_d = cnt_q;
    if (out_hs && anomaly_q) cnt_d = sat_inc16(cnt_q);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign anomaly_cnt = cnt_q;
`else
  assign anomaly_cnt = 16'd0;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign path_len  = path_len_q;
  assign anomaly   = anomaly_q;
  assign cfg_err   = cfg_err_q;

endmodule
